// File: rtl/instr_encoder_pkg.sv
// Shared ExtOp codes and encoder result type; the codes match the immediate
// extractor and decoder control so all three agree on immediate formats.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    EXTOP_I = 3'b000,
    EXTOP_U = 3'b001,
    EXTOP_S = 3'b010,
    EXTOP_B = 3'b011,
    EXTOP_J = 3'b100
  } ext_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } pack_res_t;

  localparam int signed Imm12Min = -2048;
  localparam int signed Imm12Max = 2047;
  localparam int signed Imm13Min = -4096;
  localparam int signed Imm13Max = 4094;
  localparam int signed Imm21Min = -(2 ** 20);
  localparam int signed Imm21Max = (2 ** 20) - 2;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational RV32I field packer with immediate range/alignment check.
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  ExtOp,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output pack_res_t   res
);

  logic signed [31:0] imm_s;
  assign imm_s = $signed(imm);

  always_comb begin
    res = '0;
    unique case (ExtOp)
      EXTOP_I: begin
        res.instr = {imm[11:0], rs1, funct3, rd, opcode};
        res.err   = (imm_s < Imm12Min) || (imm_s > Imm12Max);
      end
      EXTOP_U: begin
        res.instr = {imm[31:12], rd, opcode};
        res.err   = (imm[11:0] != '0);
      end
      EXTOP_S: begin
        res.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        res.err   = (imm_s < Imm12Min) || (imm_s > Imm12Max);
      end
      EXTOP_B: begin
        res.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        res.err   = (imm_s < Imm13Min) || (imm_s > Imm13Max) || imm[0];
      end
      EXTOP_J: begin
        res.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        res.err   = (imm_s < Imm21Min) || (imm_s > Imm21Max) || imm[0];
      end
      default: begin
        // Reserved ExtOp: emit a zero word flagged as an error.
        res.instr = '0;
        res.err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs fields into RV32I words and streams them with word
// addresses through a registered output stage backed by a 1-entry skid buffer.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ExtOp,
  input  logic [31:0]       imm,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  pack_res_t pack;

  instr_encoder_imm_pack u_imm_pack (
    .ExtOp  (ExtOp),
    .imm    (imm),
    .opcode (opcode),
    .rd     (rd),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .res    (pack)
  );

  // funct7 is reserved for a future R-type path.
  logic unused_funct7;
  assign unused_funct7 = ^funct7;

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;
  logic              skid_full_q, skid_full_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic              skid_err_q, skid_err_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              accept;
  logic [ADDR_W-1:0] beat_addr;

  always_comb begin
    accept       = in_valid & in_ready_q;
    beat_addr    = addr_load ? addr_base : cnt_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    out_err_d    = out_err_q;
    skid_full_d  = skid_full_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    skid_err_d   = skid_err_q;

    if (accept) begin
      cnt_d = beat_addr + ADDR_W'(1);
    end else if (addr_load) begin
      cnt_d = addr_base;
    end

    // in_ready_q implies an empty skid, so accept and skid drain never coincide.
    if (!out_valid_q || out_ready) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_instr_d = skid_instr_q;
        out_addr_d  = skid_addr_q;
        out_err_d   = skid_err_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_instr_d = pack.instr;
        out_addr_d  = beat_addr;
        out_err_d   = pack.err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_full_d  = 1'b1;
      skid_instr_d = pack.instr;
      skid_addr_d  = beat_addr;
      skid_err_d   = pack.err;
    end

    in_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      out_err_q    <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      skid_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      out_err_q    <= out_err_d;
      skid_full_q  <= skid_full_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      skid_err_q   <= skid_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, address wrap, skid stall, reset
// mid-stream and randomized traffic against a queue-based reference model.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 10;
  localparam int AddrMod = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ExtOp;
  logic [31:0]       imm;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_base;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ExtOp     (ExtOp),
    .imm       (imm),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct7    (funct7),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int ref_addr;

  logic [31:0]       q_instr[$];
  logic              q_err[$];
  logic [ADDR_W-1:0] q_addr[$];
  logic [2:0]        q_ext[$];
  logic [31:0]       q_imm[$];

  // Reference encoder: range rules evaluated on the integer value of imm.
  function automatic void model_encode(input logic [2:0] e, input logic [31:0] im,
                                       input logic [6:0] op, input logic [4:0] rdv,
                                       input logic [2:0] f3, input logic [4:0] r1,
                                       input logic [4:0] r2, output logic [31:0] w,
                                       output logic er);
    int v;
    v = im;
    case (e)
      3'd0: begin
        w  = {im[11:0], r1, f3, rdv, op};
        er = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        w  = {im[31:12], rdv, op};
        er = (v % 4096) != 0;
      end
      3'd2: begin
        w  = {im[11:5], r2, r1, f3, im[4:0], op};
        er = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        w  = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], op};
        er = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin
        w  = {im[20], im[10:1], im[11], im[19:12], rdv, op};
        er = (v < -(1 << 20)) || (v > (1 << 20) - 2) || (v % 2 != 0);
      end
      default: begin
        w  = '0;
        er = 1'b1;
      end
    endcase
  endfunction

  // Immediate extractor as the core implements it, used for the round-trip check.
  function automatic int extract(input logic [31:0] w, input logic [2:0] e);
    int x;
    x = 0;
    case (e)
      3'd0: begin x = w[31:20]; if (x >= 2048) x -= 4096; end
      3'd1: x = {w[31:12], 12'b0};
      3'd2: begin x = {w[31:25], w[11:7]}; if (x >= 2048) x -= 4096; end
      3'd3: begin
        x = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (x >= 4096) x -= 8192;
      end
      3'd4: begin
        x = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (x >= (1 << 20)) x -= (1 << 21);
      end
      default: x = 0;
    endcase
    return x;
  endfunction

  task automatic clear_q();
    q_instr.delete();
    q_err.delete();
    q_addr.delete();
    q_ext.delete();
    q_imm.delete();
  endtask

  task automatic drop_front();
    void'(q_instr.pop_front());
    void'(q_err.pop_front());
    void'(q_ext.pop_front());
    void'(q_imm.pop_front());
  endtask

  // Offer one beat, wait (bounded) for acceptance and record the expectation.
  task automatic send_beat(input logic [2:0] e, input logic [31:0] im, input logic [6:0] op,
                           input logic [4:0] rdv, input logic [2:0] f3, input logic [4:0] r1,
                           input logic [4:0] r2, input bit ld, input logic [ADDR_W-1:0] base);
    logic [31:0]       w;
    logic              er;
    logic [ADDR_W-1:0] a;
    bit                done;
    ExtOp = e; imm = im; opcode = op; rd = rdv; funct3 = f3; rs1 = r1; rs2 = r2;
    addr_load = ld; addr_base = base; in_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    addr_load = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      model_encode(e, im, op, rdv, f3, r1, r2, w, er);
      a = ld ? base : ADDR_W'(ref_addr);
      ref_addr = (int'(a) + 1) % AddrMod;
      q_instr.push_back(w);
      q_err.push_back(er);
      q_addr.push_back(a);
      q_ext.push_back(e);
      q_imm.push_back(im);
    end
  endtask

  task automatic get_beat(output logic [31:0] w, output logic er, output logic [ADDR_W-1:0] a,
                          output bit ok);
    ok = 1'b0; w = '0; er = 1'b0; a = '0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        w = out_instr; er = out_err; a = out_addr; ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({out_valid, out_err, in_ready} !== 3'b000 || out_instr !== 32'h0 || out_addr !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%b err=%b rdy=%b instr=%h addr=%0d, required all 0",
               out_valid, out_err, in_ready, out_instr, out_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_addr = 0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [2:0]  e;
    int          im;
    logic [6:0]  op;
    logic [4:0]  rdv;
    logic [2:0]  f3;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] w;
    bit          chk_w;
    logic        er;
  } vec_t;

  task automatic test_vectors();
    vec_t              vecs[0:19];
    logic [31:0]       w;
    logic              er;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] exp_a;
    bit                ok;
    vecs = '{
      '{3'd0, -1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFF00093, 1'b1, 1'b0},
      '{3'd1, 'h12345000, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h123452B7, 1'b1, 1'b0},
      '{3'd1, 'h12345001, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h123452B7, 1'b1, 1'b1},
      '{3'd3, 8, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'h00208463, 1'b1, 1'b0},
      '{3'd3, 3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'h00208163, 1'b1, 1'b1},
      '{3'd3, 4096, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'h80208063, 1'b1, 1'b1},
      '{3'd4, 2048, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h001000EF, 1'b1, 1'b0},
      '{3'd0, 2047, 7'h13, 5'd2, 3'd1, 5'd3, 5'd0, 32'h0, 1'b0, 1'b0},
      '{3'd0, 2048, 7'h13, 5'd2, 3'd1, 5'd3, 5'd0, 32'h0, 1'b0, 1'b1},
      '{3'd0, -2048, 7'h13, 5'd2, 3'd1, 5'd3, 5'd0, 32'h0, 1'b0, 1'b0},
      '{3'd0, -2049, 7'h13, 5'd2, 3'd1, 5'd3, 5'd0, 32'h0, 1'b0, 1'b1},
      '{3'd2, 2047, 7'h23, 5'd0, 3'd2, 5'd4, 5'd5, 32'h0, 1'b0, 1'b0},
      '{3'd2, -2049, 7'h23, 5'd0, 3'd2, 5'd4, 5'd5, 32'h0, 1'b0, 1'b1},
      '{3'd3, 4094, 7'h63, 5'd0, 3'd1, 5'd6, 5'd7, 32'h0, 1'b0, 1'b0},
      '{3'd3, -4096, 7'h63, 5'd0, 3'd1, 5'd6, 5'd7, 32'h0, 1'b0, 1'b0},
      '{3'd3, -4098, 7'h63, 5'd0, 3'd1, 5'd6, 5'd7, 32'h0, 1'b0, 1'b1},
      '{3'd4, 1048574, 7'h6F, 5'd8, 3'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0},
      '{3'd4, 1048576, 7'h6F, 5'd8, 3'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1},
      '{3'd4, -1048576, 7'h6F, 5'd8, 3'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0},
      '{3'd5, 12, 7'h13, 5'd1, 3'd0, 5'd1, 5'd1, 32'h00000000, 1'b1, 1'b1}
    };
    out_ready = 1'b1;
    clear_q();
    for (int i = 0; i < 20; i++) begin
      send_beat(vecs[i].e, vecs[i].im, vecs[i].op, vecs[i].rdv, vecs[i].f3, vecs[i].r1,
                vecs[i].r2, 1'b0, '0);
      get_beat(w, er, a, ok);
      exp_a = (q_addr.size() > 0) ? q_addr.pop_front() : '0;
      drop_front();
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL vec%0d_timeout: no output beat, required one", i);
        continue;
      end
      if (er !== vecs[i].er || a !== exp_a) begin
        bad++;
        $display("FAIL vec%0d_err_addr: err=%b addr=%0d, required err=%b addr=%0d",
                 i, er, a, vecs[i].er, exp_a);
      end
      if (vecs[i].chk_w) begin
        total++;
        if (w !== vecs[i].w) begin
          bad++;
          $display("FAIL vec%0d_instr: got %h, required %h", i, w, vecs[i].w);
        end
      end
      if (!vecs[i].er) begin
        total++;
        if (extract(w, vecs[i].e) !== vecs[i].im) begin
          bad++;
          $display("FAIL vec%0d_roundtrip: got %0d, required %0d", i, extract(w, vecs[i].e),
                   vecs[i].im);
        end
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [ADDR_W-1:0] exp_addrs[0:3];
    logic [31:0]       w;
    logic              er;
    logic [ADDR_W-1:0] a;
    bit                ok;
    exp_addrs = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(3'd0, i, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, i == 0, 10'd1022);
      get_beat(w, er, a, ok);
      total++;
      if (!ok || a !== exp_addrs[i]) begin
        bad++;
        $display("FAIL addr_wrap%0d: ok=%b addr=%0d, required %0d", i, ok, a, exp_addrs[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_skid();
    logic [31:0]       w;
    logic              er;
    logic [ADDR_W-1:0] a;
    bit                ok;
    clear_q();
    out_ready = 1'b0;
    send_beat(3'd0, 5, 7'h13, 5'd3, 3'd0, 5'd1, 5'd0, 1'b0, '0);
    send_beat(3'd2, -7, 7'h23, 5'd0, 3'd2, 5'd2, 5'd9, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== q_instr[0] ||
          out_addr !== q_addr[0]) begin
        bad++;
        $display("FAIL skid_stall%0d: rdy=%b valid=%b instr=%h addr=%0d, required 0/1/%h/%0d",
                 c, in_ready, out_valid, out_instr, out_addr, q_instr[0], q_addr[0]);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      get_beat(w, er, a, ok);
      total++;
      if (!ok || w !== q_instr[0] || er !== q_err[0] || a !== q_addr[0]) begin
        bad++;
        $display("FAIL skid_drain%0d: ok=%b instr=%h err=%b addr=%0d, required %h/%b/%0d",
                 b, ok, w, er, a, q_instr[0], q_err[0], q_addr[0]);
      end
      void'(q_addr.pop_front());
      drop_front();
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0]       w;
    logic              er;
    logic [ADDR_W-1:0] a;
    bit                ok;
    clear_q();
    out_ready = 1'b0;
    send_beat(3'd1, 32'hABCDE000, 7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 1'b0, '0);
    send_beat(3'd0, 100, 7'h13, 5'd8, 3'd0, 5'd9, 5'd0, 1'b0, '0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_addr !== '0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: valid=%b addr=%0d err=%b rdy=%b, required 0/0/0/0",
               out_valid, out_addr, out_err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_addr = 0;
    clear_q();
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_leak: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk);
    #1;
    send_beat(3'd4, -20, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0, '0);
    get_beat(w, er, a, ok);
    total++;
    if (!ok || a !== '0 || w !== q_instr[0] || er !== 1'b0) begin
      bad++;
      $display("FAIL midreset_first: ok=%b addr=%0d instr=%h err=%b, required addr 0 %h err 0",
               ok, a, w, er, q_instr[0]);
    end
    clear_q();
  endtask

  task automatic test_random(input int n);
    clear_q();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int          k;
          int          t;
          logic [31:0] r;
          logic [31:0] rb;
          logic [2:0]  e;
          logic [31:0] im;
          k = $urandom_range(0, 20);
          e = (k < 18) ? 3'(k % 5) : 3'(k - 13);
          r = $urandom;
          rb = $urandom;
          if ($urandom_range(0, 3) == 0) begin
            im = $urandom;
          end else begin
            case (e)
              3'd0, 3'd2: begin t = $urandom_range(0, 4095); im = t - 2048; end
              3'd3: begin t = $urandom_range(0, 4095); im = (t - 2048) * 2; end
              3'd4: begin t = $urandom_range(0, 1048575); im = (t - 524288) * 2; end
              3'd1: im = rb & 32'hFFFF_F000;
              default: im = rb;
            endcase
          end
          funct7 = r[31:25];
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_beat(e, im, r[6:0], r[11:7], r[14:12], r[19:15], r[24:20],
                    $urandom_range(0, 15) == 0, rb[ADDR_W-1:0]);
        end
      end
      begin
        int                cnt;
        int                cyc;
        bit                held;
        logic [31:0]       h_instr;
        logic [ADDR_W-1:0] h_addr;
        logic              h_err;
        logic [31:0]       ei;
        logic [ADDR_W-1:0] ea;
        logic              ee;
        logic [2:0]        ex;
        logic [31:0]       eim;
        cnt = 0; cyc = 0; held = 1'b0;
        while (cnt < n && cyc < n * 20) begin
          @(negedge clk);
          cyc++;
          if (held) begin
            total++;
            if (out_valid !== 1'b1 || out_instr !== h_instr || out_addr !== h_addr ||
                out_err !== h_err) begin
              bad++;
              $display("FAIL rand_hold: valid=%b instr=%h addr=%0d, required 1/%h/%0d",
                       out_valid, out_instr, out_addr, h_instr, h_addr);
            end
          end
          held = 1'b0;
          if (out_valid && out_ready) begin
            total++;
            if (q_instr.size() == 0) begin
              bad++;
              $display("FAIL rand_extra: unexpected beat %h, required none", out_instr);
            end else begin
              ei = q_instr.pop_front(); ee = q_err.pop_front(); ea = q_addr.pop_front();
              ex = q_ext.pop_front(); eim = q_imm.pop_front();
              if (out_instr !== ei || out_err !== ee || out_addr !== ea) begin
                bad++;
                $display("FAIL rand_beat%0d: instr=%h err=%b addr=%0d, required %h/%b/%0d",
                         cnt, out_instr, out_err, out_addr, ei, ee, ea);
              end
              if (!ee) begin
                total++;
                if (extract(out_instr, ex) !== int'(eim)) begin
                  bad++;
                  $display("FAIL rand_roundtrip%0d: got %0d, required %0d", cnt,
                           extract(out_instr, ex), int'(eim));
                end
              end
            end
            cnt++;
          end else if (out_valid) begin
            held = 1'b1;
            h_instr = out_instr; h_addr = out_addr; h_err = out_err;
          end
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (cnt < n) begin
          total++; bad++;
          $display("FAIL rand_timeout: %0d beats seen, required %0d", cnt, n);
        end
      end
    join
    out_ready = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; ref_addr = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_base = '0;
    ExtOp = '0; imm = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0;
    test_reset();
    test_vectors();
    test_addr_wrap();
    test_skid();
    test_reset_midstream();
    test_random(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
